// File: rtl/recur_pkg.sv
// recur_pkg: shared widths, op encoding and sizing helper for the recursion stack
package recur_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF = 4096;
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_POP = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/recur_stack_regfile_if.sv
// recur_stack_regfile_if: controller-side bus of the recursion stack register file
interface recur_stack_regfile_if #(
    parameter int DATA_W = recur_pkg::DATA_W_DEF,
    parameter int DEPTH = recur_pkg::DEPTH_DEF,
    parameter int N_RD = 2
);
    localparam int ADDR_W = recur_pkg::clog2(DEPTH);
    logic clr;
    logic we;
    logic [DATA_W-1:0] w_data;
    logic pop;
    logic seq_re;
    logic [DATA_W-1:0] seq_r_data;
    logic [N_RD-1:0] ran_re;
    logic [N_RD*ADDR_W-1:0] ran_r_addr;
    logic [N_RD*DATA_W-1:0] ran_r_data;
    logic [N_RD-1:0] ran_r_valid;
    logic [N_RD-1:0] ran_r_err;
    logic [ADDR_W:0] count;
    logic empty;
    logic full;
    logic ovf;
    logic unf;
    modport master (
        output clr, we, w_data, pop, seq_re, ran_re, ran_r_addr,
        input seq_r_data, ran_r_data, ran_r_valid, ran_r_err, count, empty, full, ovf, unf
    );
    modport slave (
        input clr, we, w_data, pop, seq_re, ran_re, ran_r_addr,
        output seq_r_data, ran_r_data, ran_r_valid, ran_r_err, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/recur_rd_port.sv
// recur_rd_port: one registered random-read port with range check against the pre-edge count
module recur_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o
);
    logic in_range;
    logic [DATA_W-1:0] data_q, data_d;
    logic valid_q, err_q;
    always_comb begin
        in_range = {1'b0, addr_i} < count_i;
        data_d = re_i ? (in_range ? mem_data_i : '0) : data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            data_q <= data_d;
            valid_q <= re_i;
            err_q <= re_i && !in_range;
        end
    end
    assign data_o = data_q;
    assign valid_o = valid_q;
    assign err_o = err_q;
endmodule

// File: rtl/recur_stack_regfile.sv
// recur_stack_regfile: LIFO register file with combinational top read and registered random reads
module recur_stack_regfile import recur_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int N_RD = 2
) (
    input logic clk,
    input logic rst,
    recur_stack_regfile_if.slave bus
);
    localparam int ADDR_W = clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0] count_q, count_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic empty, full, push_ok, pop_ok, repl_ok, wr_en;
    logic [1:0] op;
    logic [ADDR_W-1:0] top_idx, wr_idx;
    logic [N_RD-1:0][DATA_W-1:0] rd_data;
    logic [N_RD-1:0] rd_valid, rd_err;
    always_comb begin
        op = {bus.we, bus.pop};
        empty = count_q == '0;
        full = count_q == (ADDR_W+1)'(DEPTH);
        top_idx = count_q[ADDR_W-1:0] - 1'b1;
        // replace on an empty stack degrades to a plain push
        push_ok = (op == OP_PUSH && !full) || (op == OP_REPL && empty);
        pop_ok = op == OP_POP && !empty;
        repl_ok = op == OP_REPL && !empty;
        wr_en = !rst && !bus.clr && (push_ok || repl_ok);
        wr_idx = repl_ok ? top_idx : count_q[ADDR_W-1:0];
        count_d = bus.clr ? '0 : push_ok ? count_q + 1'b1 : pop_ok ? count_q - 1'b1 : count_q;
        ovf_d = !bus.clr && (ovf_q || (op == OP_PUSH && full));
        unf_d = !bus.clr && (unf_q || (op == OP_POP && empty));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= bus.w_data;
    end
    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        recur_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
            .clk        (clk),
            .rst        (rst),
            .re_i       (bus.ran_re[i]),
            .addr_i     (bus.ran_r_addr[i*ADDR_W +: ADDR_W]),
            .count_i    (count_q),
            .mem_data_i (mem_q[bus.ran_r_addr[i*ADDR_W +: ADDR_W]]),
            .data_o     (rd_data[i]),
            .valid_o    (rd_valid[i]),
            .err_o      (rd_err[i])
        );
    end
    assign bus.seq_r_data = (bus.seq_re && !empty) ? mem_q[top_idx] : '0;
    assign bus.ran_r_data = rd_data;
    assign bus.ran_r_valid = rd_valid;
    assign bus.ran_r_err = rd_err;
    assign bus.count = count_q;
    assign bus.empty = empty;
    assign bus.full = full;
    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
endmodule

// File: tb/tb_recur_stack_regfile.sv
// tb_recur_stack_regfile: directed stimulus with a queue scoreboard for random-read responses
module tb_recur_stack_regfile;
    typedef struct packed {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    rsp_t q [2][$];
    recur_stack_regfile_if #(.DATA_W(32), .DEPTH(4), .N_RD(2)) bus ();
    recur_stack_regfile #(.DATA_W(32), .DEPTH(4), .N_RD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (bus.ran_r_valid[p] === 1'b1) begin
                if (q[p].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd%0d_unexpected got valid=1 want valid=0", p);
                end else begin
                    rsp_t e;
                    e = q[p].pop_front();
                    chk($sformatf("rd%0d_data", p), bus.ran_r_data[p*32 +: 32], e.data);
                    chk($sformatf("rd%0d_err", p), {31'b0, bus.ran_r_err[p]}, {31'b0, e.err});
                end
            end else if (q[p].size() != 0 && q[p][0].due <= cyc) begin
                rsp_t e;
                e = q[p].pop_front();
                checks++;
                errors++;
                $display("FAIL rd%0d_missing got valid=0 want valid=1 data=%0h", p, e.data);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.pop = 1'b0;
        bus.clr = 1'b0;
        bus.ran_re = '0;
    endtask
    task automatic push(input logic [31:0] d);
        bus.we = 1'b1;
        bus.w_data = d;
    endtask
    task automatic rd(input int p, input logic [1:0] a, input logic [31:0] d, input logic e);
        rsp_t r;
        bus.ran_re[p] = 1'b1;
        bus.ran_r_addr[p*2 +: 2] = a;
        r.due = cyc + 1;
        r.data = d;
        r.err = e;
        q[p].push_back(r);
    endtask
    initial begin
        bus.clr = 1'b0;
        bus.we = 1'b0;
        bus.pop = 1'b0;
        bus.w_data = '0;
        bus.seq_re = 1'b1;
        bus.ran_re = '0;
        bus.ran_r_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_flags", {29'b0, bus.full, bus.ovf, bus.unf}, 0);
        chk("rst_rd", {bus.ran_r_data[31:0], bus.ran_r_data[63:32]} == '0 ? 32'(bus.ran_r_valid | bus.ran_r_err) : 32'hdead, 0);
        chk("rst_seq", bus.seq_r_data, 0);
        push(32'h11); tick();
        push(32'h22); tick();
        push(32'h33); tick();
        chk("t1_count", 32'(bus.count), 3);
        chk("t1_seq", bus.seq_r_data, 32'h33);
        chk("t1_empty", 32'(bus.empty), 0);
        rd(0, 2'd1, 32'h22, 1'b0); tick();
        bus.pop = 1'b1; tick();
        chk("t2_pop_count", 32'(bus.count), 2);
        chk("t2_pop_seq", bus.seq_r_data, 32'h22);
        push(32'hAA); bus.pop = 1'b1; tick();
        chk("t2_repl_count", 32'(bus.count), 2);
        chk("t2_repl_seq", bus.seq_r_data, 32'hAA);
        rd(0, 2'd2, 32'h0, 1'b1); tick();
        bus.clr = 1'b1; tick();
        for (int i = 1; i <= 4; i++) begin
            push(32'(i)); tick();
        end
        chk("t3_full", 32'(bus.full), 1);
        chk("t3_count4", 32'(bus.count), 4);
        push(32'h5); tick();
        chk("t3_ovf", 32'(bus.ovf), 1);
        chk("t3_ovf_count", 32'(bus.count), 4);
        chk("t3_ovf_seq", bus.seq_r_data, 32'h4);
        for (int i = 0; i < 4; i++) begin
            bus.pop = 1'b1; tick();
        end
        chk("t3_empty", 32'(bus.empty), 1);
        chk("t3_unf_clear", 32'(bus.unf), 0);
        bus.pop = 1'b1; tick();
        chk("t3_unf", 32'(bus.unf), 1);
        chk("t3_unf_count", 32'(bus.count), 0);
        bus.clr = 1'b1; tick();
        push(32'h77); bus.pop = 1'b1; tick();
        chk("t3_replempty_count", 32'(bus.count), 1);
        chk("t3_replempty_seq", bus.seq_r_data, 32'h77);
        chk("t3_replempty_unf", 32'(bus.unf), 0);
        bus.pop = 1'b1; tick();
        push(32'hA0); tick();
        push(32'hA1); tick();
        push(32'hA2); tick();
        push(32'hA3); rd(0, 2'd0, 32'hA0, 1'b0); rd(1, 2'd3, 32'h0, 1'b1); tick();
        chk("t4_count", 32'(bus.count), 4);
        rd(1, 2'd3, 32'hA3, 1'b0); tick();
        tick();
        chk("t4_hold_data", bus.ran_r_data[63:32], 32'hA3);
        chk("t4_hold_valid", 32'(bus.ran_r_valid), 0);
        push(32'hA4); tick();
        chk("t4_ovf", 32'(bus.ovf), 1);
        bus.pop = 1'b1; tick();
        bus.pop = 1'b1; tick();
        chk("t5_pre_count", 32'(bus.count), 2);
        bus.clr = 1'b1; push(32'hEE); tick();
        chk("t5_clr_count", 32'(bus.count), 0);
        chk("t5_clr_ovf", 32'(bus.ovf), 0);
        chk("t5_clr_empty", 32'(bus.empty), 1);
        chk("t5_clr_seq", bus.seq_r_data, 0);
        push(32'h66); tick();
        rst = 1'b1; bus.ran_re = 2'b11; bus.ran_r_addr = '0; push(32'h99); tick();
        rst = 1'b0;
        chk("t5_rst_count", 32'(bus.count), 0);
        chk("t5_rst_data0", bus.ran_r_data[31:0], 0);
        chk("t5_rst_data1", bus.ran_r_data[63:32], 0);
        chk("t5_rst_valid_err", {30'b0, bus.ran_r_valid | bus.ran_r_err}, 0);
        chk("t5_rst_flags", {30'b0, bus.ovf, bus.unf}, 0);
        chk("t5_rst_seq", bus.seq_r_data, 0);
        tick();
        tick();
        chk("sb_drained", 32'(q[0].size() + q[1].size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
